fan_speed_sequencer: RTL and testbench
======================================

# fan_speed_sequencer

Speed and auto-off controller placed in front of `FAN_control`. It turns one-cycle user button pulses into the 2-bit `i_FANspeed` level that `FAN_control` consumes. Increases in speed are applied as a soft-start ramp, one level at a time; decreases and off requests take effect immediately. It also runs an auto-off countdown timer whose remaining seconds are exported for display.

## Interface
- `TICK_DIV`, default 100_000: sysclk cycles per 1 ms tick (100 MHz).
- `RAMP_MS`, default 500: dwell in ms ticks between successive ramp-up steps.
- `MS_PER_S`, default 1000: ms ticks per second.
- `TIMER_UNIT_S`, default 60: seconds per timer unit. Timer presets are 1, 3 and 5 units.

Ports:
- `sysclk`  in  1  system clock.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_btn_speed`  in  1  one-cycle pulse, already debounced: select the next target speed.
- `i_btn_off`  in  1  one-cycle pulse: fan off, timer cleared.
- `i_btn_timer`  in  1  one-cycle pulse: select the next timer preset.
- `o_FANspeed`  out  2  applied level, 0 = off, 1..3 = low/mid/high. Drives `FAN_control.i_FANspeed`.
- `o_target`  out  2  requested level.
- `o_ramping`  out  1  high while `o_FANspeed` < `o_target`.
- `o_timer_on`  out  1  auto-off countdown armed.
- `o_timer_sec`  out  9  remaining seconds, 0 when disarmed.

## Operation
- State machine: OFF, RAMP, RUN.
- **OFF**
  - `o_target` = 0 and `o_FANspeed` = 0.
  - `i_btn_speed` sets target to 1 and moves to RAMP.
  - `i_btn_timer` is ignored in OFF.
- **Target cycling (RAMP or RUN)**
  - Each `i_btn_speed` advances the target 1→2→3→1, wrapping from 3 back to 1.
  - If the new target is above `o_FANspeed`, go to RAMP. Otherwise `o_FANspeed` takes the new target directly and the state is RUN.
- **RAMP**
  - `o_FANspeed` increments by 1 on entry.
  - After that it increments once every `RAMP_MS` ms ticks until it equals the target, then moves to RUN.
  - The dwell counter clears on every step and on every target change.
- **RUN**
  - `o_FANspeed` == `o_target`. State is held.
- **`i_btn_off`** (any state)
  - Go to OFF, target = 0, speed = 0, timer disarmed.
  - Has priority over every other input in the same cycle.
- **Timer presets**
  - `i_btn_timer` in RAMP or RUN cycles through none → 1 unit → 3 units → 5 units → none.
  - Selecting a preset loads `o_timer_sec` = preset × `TIMER_UNIT_S` and clears the second-prescaler.
  - Selecting none disarms the timer.
- **Countdown**
  - While armed, `o_timer_sec` decrements once every `MS_PER_S` ms ticks.
  - The decrement from 1 to 0 forces OFF with the same effect as `i_btn_off`.
- **Simultaneous inputs**
  - `i_btn_speed` and `i_btn_timer` in the same cycle are both applied.
  - `i_btn_speed` from OFF together with `i_btn_timer` arms the timer, using the post-transition state.
  - Timer expiry in the same cycle as `i_btn_speed` resolves to OFF.
- **Width rules**
  - `o_timer_sec` is 9 bits; 5 × 60 = 300 fits.
  - The elaboration check requires 5 × `TIMER_UNIT_S` ≤ 511.

## Timing
- **Reset values**: all outputs 0, state OFF, ms prescaler 0, dwell counter 0, second counter 0.
- **Button latency**: one cycle. A pulse sampled at edge N is visible on the outputs after edge N.
- **First ramp step**: same edge as the button. The next step is exactly `RAMP_MS` ms ticks later.
- **Full ramp from OFF to 3 with a single press**:
  - This case does not arise, because one press only targets 1.
  - For target 3 reached through presses while at 1, `o_FANspeed` becomes 2 on the press edge.
  - It becomes 3 after `RAMP_MS` ticks.
- **ms prescaler**:
  - Free-running over 0..`TICK_DIV`-1.
  - The tick is a one-cycle strobe when the counter wraps.
  - The prescaler is not cleared by buttons.
- **Reset during ramp or countdown**: returns to the reset values on the next edge. No partial state is retained.

## Structure
- **Package `fan_pkg`**
  - Speed constants: `SPD_OFF`, `SPD_LOW`, `SPD_MID`, `SPD_HIGH`.
  - State enum: OFF, RAMP, RUN.
  - Timer preset index enum and the preset-units constants 1, 3, 5.
- **Sub-module `fan_tick_gen`**
  - Parameter `TICK_DIV`; output is a one-cycle `o_tick_1ms` strobe.
  - Reused for the ms base. The second counter stays inside the sequencer.
- Expected size: about 200 lines of RTL.

## Test plan
Bench parameters: `TICK_DIV`=4, `RAMP_MS`=3, `MS_PER_S`=2, `TIMER_UNIT_S`=2.
- **Reset**: assert `i_rst` for 3 cycles → all outputs 0, state OFF. `i_btn_timer` pulsed in OFF → `o_timer_on` stays 0.
- **Ramp**: speed press ×3, spaced 1 cycle apart, from OFF.
  - Target reads 1, 2, 3.
  - `o_FANspeed` reads 1, then 2 on the second press, then 3 exactly 12 cycles after the last step.
  - `o_ramping` falls on the same edge.
- **Wrap and decrease**: at speed 3, press speed → target 1, `o_FANspeed` 1 next cycle, no ramp.
- **Timer**: at speed 2, press timer twice.
  - After the first press `o_timer_sec`=2; after the second press it is reloaded to 6.
  - It decrements every 8 cycles.
  - At 0 the fan goes OFF and `o_timer_on`=0.
- **Priority**: `i_btn_off` and `i_btn_speed` in the same cycle while running → OFF, all outputs 0.
- **Reset mid-ramp**: `i_rst` during RAMP with the timer armed → next edge all zero. A later speed press restarts the ramp from 1.

Source files
------------

// File: rtl/fan_pkg.sv
// Shared constants, states and timer presets for the fan speed sequencer.
// Imported by the sequencer top.
package fan_pkg;

    localparam logic [1:0] SPD_OFF  = 2'd0;
    localparam logic [1:0] SPD_LOW  = 2'd1;
    localparam logic [1:0] SPD_MID  = 2'd2;
    localparam logic [1:0] SPD_HIGH = 2'd3;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_RAMP,
        ST_RUN
    } fan_state_t;

    typedef enum logic [1:0] {
        TMR_NONE,
        TMR_1,
        TMR_3,
        TMR_5
    } tmr_sel_t;

    localparam int unsigned TMR_UNITS_1   = 1;
    localparam int unsigned TMR_UNITS_3   = 3;
    localparam int unsigned TMR_UNITS_5   = 5;
    localparam int unsigned TMR_UNITS_MAX = TMR_UNITS_5;

    // Target cycling wraps high back to low, never to off.
    function automatic logic [1:0] spd_next(input logic [1:0] s);
        return (s == SPD_HIGH) ? SPD_LOW : s + 2'd1;
    endfunction

    function automatic tmr_sel_t tmr_next(input tmr_sel_t s);
        tmr_sel_t r;
        unique case (s)
            TMR_NONE: r = TMR_1;
            TMR_1:    r = TMR_3;
            TMR_3:    r = TMR_5;
            TMR_5:    r = TMR_NONE;
        endcase
        return r;
    endfunction

    function automatic int unsigned tmr_units(input tmr_sel_t s);
        int unsigned u;
        unique case (s)
            TMR_NONE: u = 0;
            TMR_1:    u = TMR_UNITS_1;
            TMR_3:    u = TMR_UNITS_3;
            TMR_5:    u = TMR_UNITS_5;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/fan_speed_sequencer_tick_gen.sv
// Free-running ms prescaler: o_tick_1ms strobes for one cycle as it wraps.
// Ports: sysclk, i_rst (sync, active-high), o_tick_1ms.
module fan_tick_gen #(
    parameter int unsigned TICK_DIV = 100_000
) (
    input  logic sysclk,
    input  logic i_rst,
    output logic o_tick_1ms
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge sysclk) begin
        if (i_rst)
            cnt <= '0;
        else if (cnt == CNT_MAX)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    assign o_tick_1ms = (cnt == CNT_MAX);

endmodule

// File: rtl/fan_speed_sequencer.sv
// Button-driven fan speed sequencer: soft-start ramp up, instant decrease,
// auto-off timer. Ports: sysclk, i_rst, i_btn_speed/off/timer pulses in;
// o_FANspeed, o_target, o_ramping, o_timer_on, o_timer_sec out.
module fan_speed_sequencer
    import fan_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 100_000,
    parameter int unsigned RAMP_MS      = 500,
    parameter int unsigned MS_PER_S     = 1000,
    parameter int unsigned TIMER_UNIT_S = 60
) (
    input  logic       sysclk,
    input  logic       i_rst,
    input  logic       i_btn_speed,
    input  logic       i_btn_off,
    input  logic       i_btn_timer,
    output logic [1:0] o_FANspeed,
    output logic [1:0] o_target,
    output logic       o_ramping,
    output logic       o_timer_on,
    output logic [8:0] o_timer_sec
);

    if (TMR_UNITS_MAX * TIMER_UNIT_S > 511) begin : g_chk_sec
        $error("largest timer preset does not fit in 9 bits");
    end
    if (RAMP_MS < 1 || MS_PER_S < 1 || TIMER_UNIT_S < 1) begin : g_chk_par
        $error("RAMP_MS, MS_PER_S and TIMER_UNIT_S must be >= 1");
    end

    localparam int unsigned DW = (RAMP_MS > 1) ? $clog2(RAMP_MS) : 1;
    localparam int unsigned PW = (MS_PER_S > 1) ? $clog2(MS_PER_S) : 1;
    localparam logic [DW-1:0] DWELL_MAX = DW'(RAMP_MS - 1);
    localparam logic [PW-1:0] SPRE_MAX  = PW'(MS_PER_S - 1);

    function automatic logic [8:0] preset_sec(input tmr_sel_t s);
        return 9'(tmr_units(s) * TIMER_UNIT_S);
    endfunction

    logic tick;

    fan_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .sysclk     (sysclk),
        .i_rst      (i_rst),
        .o_tick_1ms (tick)
    );

    fan_state_t    state,  state_n;
    logic [1:0]    target, target_n;
    logic [1:0]    speed,  speed_n;
    logic [DW-1:0] dwell,  dwell_n;
    tmr_sel_t      tsel,   tsel_n;
    logic [8:0]    tsec,   tsec_n;
    logic [PW-1:0] spre,   spre_n;
    logic [1:0]    nxt_tgt;
    logic          expire;

    always_ff @(posedge sysclk) begin
        if (i_rst) begin
            state  <= ST_OFF;
            target <= SPD_OFF;
            speed  <= SPD_OFF;
            dwell  <= '0;
            tsel   <= TMR_NONE;
            tsec   <= '0;
            spre   <= '0;
        end else begin
            state  <= state_n;
            target <= target_n;
            speed  <= speed_n;
            dwell  <= dwell_n;
            tsel   <= tsel_n;
            tsec   <= tsec_n;
            spre   <= spre_n;
        end
    end

    always_comb begin
        state_n  = state;
        target_n = target;
        speed_n  = speed;
        dwell_n  = dwell;
        tsel_n   = tsel;
        tsec_n   = tsec;
        spre_n   = spre;
        nxt_tgt  = spd_next(target);
        expire   = 1'b0;

        unique case (state)
            ST_OFF: begin
                if (i_btn_speed) begin
                    target_n = SPD_LOW;
                    speed_n  = SPD_LOW;
                    dwell_n  = '0;
                    state_n  = ST_RAMP;
                end
            end
            ST_RAMP, ST_RUN: begin
                if (i_btn_speed) begin
                    target_n = nxt_tgt;
                    dwell_n  = '0;
                    if (nxt_tgt > speed) begin
                        state_n = ST_RAMP;
                        // Only a fresh ramp steps at once; a retarget
                        // mid-ramp just restarts the dwell.
                        if (state == ST_RUN)
                            speed_n = speed + 2'd1;
                    end else begin
                        speed_n = nxt_tgt;
                        state_n = ST_RUN;
                    end
                end else if (state == ST_RAMP) begin
                    if (speed >= target) begin
                        state_n = ST_RUN;
                    end else if (tick) begin
                        if (dwell == DWELL_MAX) begin
                            speed_n = speed + 2'd1;
                            dwell_n = '0;
                        end else begin
                            dwell_n = dwell + DW'(1);
                        end
                    end
                end
            end
            default: state_n = ST_OFF;
        endcase

        // A speed press out of OFF counts as running for the timer.
        if (i_btn_timer && (state != ST_OFF || i_btn_speed)) begin
            tsel_n = tmr_next(tsel);
            tsec_n = preset_sec(tmr_next(tsel));
            spre_n = '0;
        end else if (tsel != TMR_NONE && tick && tsec != 9'd0) begin
            if (spre == SPRE_MAX) begin
                spre_n = '0;
                tsec_n = tsec - 9'd1;
                expire = (tsec == 9'd1);
            end else begin
                spre_n = spre + PW'(1);
            end
        end

        if (i_btn_off || expire) begin
            state_n  = ST_OFF;
            target_n = SPD_OFF;
            speed_n  = SPD_OFF;
            dwell_n  = '0;
            tsel_n   = TMR_NONE;
            tsec_n   = '0;
            spre_n   = '0;
        end
    end

    assign o_FANspeed  = speed;
    assign o_target    = target;
    assign o_ramping   = (speed < target);
    assign o_timer_on  = (tsel != TMR_NONE);
    assign o_timer_sec = tsec;

endmodule

// File: tb/tb_fan_speed_sequencer.sv
// Directed self-checking bench for fan_speed_sequencer.
// Small parameters: 4-cycle ms tick, 3-tick ramp dwell, 2 ticks/s, 2 s unit.
module tb_fan_speed_sequencer;

    logic       sysclk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_btn_speed = 1'b0;
    logic       i_btn_off = 1'b0;
    logic       i_btn_timer = 1'b0;
    logic [1:0] o_FANspeed;
    logic [1:0] o_target;
    logic       o_ramping;
    logic       o_timer_on;
    logic [8:0] o_timer_sec;

    int n_chk = 0;
    int n_pass = 0;
    int k = 0;

    fan_speed_sequencer #(
        .TICK_DIV     (4),
        .RAMP_MS      (3),
        .MS_PER_S     (2),
        .TIMER_UNIT_S (2)
    ) dut (
        .sysclk      (sysclk),
        .i_rst       (i_rst),
        .i_btn_speed (i_btn_speed),
        .i_btn_off   (i_btn_off),
        .i_btn_timer (i_btn_timer),
        .o_FANspeed  (o_FANspeed),
        .o_target    (o_target),
        .o_ramping   (o_ramping),
        .o_timer_on  (o_timer_on),
        .o_timer_sec (o_timer_sec)
    );

    always #5 sysclk = ~sysclk;

    // Edges since reset release; ms ticks land on edges with k % 4 == 0.
    always @(posedge sysclk) begin
        if (i_rst) k <= 0;
        else       k <= k + 1;
    end

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic pulse(input logic s, input logic o, input logic t);
        i_btn_speed = s;
        i_btn_off   = o;
        i_btn_timer = t;
        step(1);
        i_btn_speed = 1'b0;
        i_btn_off   = 1'b0;
        i_btn_timer = 1'b0;
    endtask

    task automatic wait_phase(input int p);
        for (int i = 0; i < 4 && (k % 4) != p; i++) step(1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_spd"}, 16'(o_FANspeed), 16'd0);
        chk({tag, "_tgt"}, 16'(o_target), 16'd0);
        chk({tag, "_rmp"}, 16'(o_ramping), 16'd0);
        chk({tag, "_ton"}, 16'(o_timer_on), 16'd0);
        chk({tag, "_sec"}, 16'(o_timer_sec), 16'd0);
    endtask

    initial begin
        int gap;
        int cnt;
        logic [8:0] prev;

        step(3);
        chk_zero("rst");
        i_rst = 1'b0;

        pulse(0, 0, 1);
        chk("off_tmr_ton", 16'(o_timer_on), 16'd0);
        chk("off_tmr_sec", 16'(o_timer_sec), 16'd0);

        // Ramp: second press lands on a tick edge (k % 4 == 0).
        wait_phase(1);
        pulse(1, 0, 0);
        chk("p1_tgt", 16'(o_target), 16'd1);
        chk("p1_spd", 16'(o_FANspeed), 16'd1);
        step(1);
        pulse(1, 0, 0);
        chk("p2_tgt", 16'(o_target), 16'd2);
        chk("p2_spd", 16'(o_FANspeed), 16'd2);
        pulse(1, 0, 0);
        chk("p3_tgt", 16'(o_target), 16'd3);
        chk("p3_spd", 16'(o_FANspeed), 16'd2);
        chk("p3_rmp", 16'(o_ramping), 16'd1);
        step(10);
        chk("r11_spd", 16'(o_FANspeed), 16'd2);
        chk("r11_rmp", 16'(o_ramping), 16'd1);
        step(1);
        chk("r12_spd", 16'(o_FANspeed), 16'd3);
        chk("r12_rmp", 16'(o_ramping), 16'd0);

        // Wrap 3 -> 1 applies immediately.
        pulse(1, 0, 0);
        chk("wrap_tgt", 16'(o_target), 16'd1);
        chk("wrap_spd", 16'(o_FANspeed), 16'd1);
        chk("wrap_rmp", 16'(o_ramping), 16'd0);

        // Timer at speed 2.
        pulse(1, 0, 0);
        chk("t_spd", 16'(o_FANspeed), 16'd2);
        step(1);
        pulse(0, 0, 1);
        chk("t1_ton", 16'(o_timer_on), 16'd1);
        chk("t1_sec", 16'(o_timer_sec), 16'd2);
        pulse(0, 0, 1);
        chk("t3_sec", 16'(o_timer_sec), 16'd6);
        gap = ((k % 4) == 0) ? 8 : (4 - (k % 4)) + 4;
        prev = o_timer_sec;
        for (int v = 5; v >= 0; v--) begin
            cnt = 0;
            do begin
                step(1);
                cnt++;
            end while (o_timer_sec == prev && cnt < 20);
            chk("t_gap", 16'(cnt), 16'(gap));
            chk("t_sec", 16'(o_timer_sec), 16'(v));
            prev = o_timer_sec;
            gap = 8;
            if (v == 1) chk("t_run_spd", 16'(o_FANspeed), 16'd2);
        end
        chk_zero("expire");

        // Off beats speed in the same cycle.
        pulse(1, 0, 0);
        step(1);
        pulse(0, 0, 1);
        chk("pri_ton", 16'(o_timer_on), 16'd1);
        pulse(1, 1, 0);
        chk_zero("pri");

        // Reset mid-ramp with the timer armed.
        pulse(1, 0, 0);
        step(1);
        pulse(1, 0, 0);
        pulse(1, 0, 1);
        chk("mr_tgt", 16'(o_target), 16'd3);
        chk("mr_rmp", 16'(o_ramping), 16'd1);
        chk("mr_sec", 16'(o_timer_sec), 16'd2);
        i_rst = 1'b1;
        step(1);
        chk_zero("mrst");
        i_rst = 1'b0;
        pulse(1, 0, 0);
        chk("mrst_spd", 16'(o_FANspeed), 16'd1);
        chk("mrst_tgt", 16'(o_target), 16'd1);

        // Speed and timer together from OFF arm the timer.
        pulse(0, 1, 0);
        pulse(1, 0, 1);
        chk("st_spd", 16'(o_FANspeed), 16'd1);
        chk("st_ton", 16'(o_timer_on), 16'd1);
        chk("st_sec", 16'(o_timer_sec), 16'd2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
